// File: rtl/display_owner_arbiter_pkg.sv
// Shared state encodings and counter sizing for the display ownership arbiter.
// No logic of its own; imported by the arbiter and its picker.
package display_owner_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_OWNED = 2'd2
    } state_e;

    // Bits needed to hold a count of 0..cycles, never less than one.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/display_owner_arbiter_picker.sv
// Combinational round-robin search: first asserted request above lastIndex, wrapping,
// optionally skipping one index. Zero latency, no flow control.
module round_robin_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] lastIndex,
    input  logic          excludeEnable,
    input  logic [IW-1:0] excludeIndex,
    output logic          valid,
    output logic [IW-1:0] winner
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // k runs to N so lastIndex itself is the final candidate.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(lastIndex) + k) % N;
            if (!valid && request[idx] &&
                !(excludeEnable && (excludeIndex == IW'(idx)))) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/display_owner_arbiter.sv
// Round-robin owner of a shared seven-segment display with minimum hold and blank gap.
// Image/point outputs follow the owner's inputs by one cycle; requesters simply wait.
module display_owner_arbiter
    import display_owner_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int NUM_DIGITS     = 8,
    parameter int HOLD_CYCLES    = 1000000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic                                 clock,
    input  logic                                 resetN,
    input  logic [NUM_REQUESTERS-1:0]            request,
    input  logic [NUM_REQUESTERS*NUM_DIGITS*4-1:0] requestData,
    input  logic [NUM_REQUESTERS*NUM_DIGITS-1:0] requestPoint,
    output logic [NUM_REQUESTERS-1:0]            grant,
    output logic [NUM_DIGITS*4-1:0]              data,
    output logic [NUM_DIGITS-1:0]                pointEnable,
    output logic                                 displayEnable
);

    localparam int IW = $clog2(NUM_REQUESTERS);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int BW = cnt_width(BLANK_CYCLES);
    localparam int DW = NUM_DIGITS * 4;
    localparam int PW = NUM_DIGITS;

    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_INIT = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] LAST_RESET = IW'(NUM_REQUESTERS - 1);

    state_e                    state_q, state_d;
    logic [IW-1:0]             pending_q, pending_d;
    logic [IW-1:0]             last_q, last_d;
    logic [HW-1:0]             hold_q, hold_d;
    logic [BW-1:0]             blank_q, blank_d;
    logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
    logic [DW-1:0]             data_q, data_d;
    logic [PW-1:0]             point_q, point_d;
    logic                      disp_q, disp_d;

    logic                      pick_vld;
    logic [IW-1:0]             pick_idx;
    logic                      owner_req;
    logic                      latch_win;

    // While owned, the current owner is never its own challenger.
    round_robin_picker #(
        .N  (NUM_REQUESTERS),
        .IW (IW)
    ) u_picker (
        .request       (request),
        .lastIndex     (last_q),
        .excludeEnable (state_q == ST_OWNED),
        .excludeIndex  (pending_q),
        .valid         (pick_vld),
        .winner        (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        last_d    = last_q;
        hold_d    = hold_q;
        blank_d   = blank_q;
        grant_d   = grant_q;
        data_d    = '0;
        point_d   = '0;
        disp_d    = 1'b0;
        latch_win = 1'b0;
        owner_req = request[pending_q];

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_vld) begin
                    latch_win = 1'b1;
                end
            end

            ST_BLANK: begin
                grant_d = '0;
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (blank_q == '0) begin
                    state_d = ST_OWNED;
                    grant_d = NUM_REQUESTERS'(1) << pending_q;
                    hold_d  = HOLD_INIT;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end

            ST_OWNED: begin
                data_d  = requestData[int'(pending_q)*DW +: DW];
                point_d = requestPoint[int'(pending_q)*PW +: PW];
                disp_d  = 1'b1;
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end
                // A drop wins over hold expiry when both land together.
                if (!owner_req) begin
                    grant_d = '0;
                    if (pick_vld) begin
                        latch_win = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if ((hold_q == '0) && pick_vld) begin
                    grant_d   = '0;
                    latch_win = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        // lastOwner only moves here, so an aborted blank keeps fairness intact.
        if (latch_win) begin
            pending_d = pick_idx;
            last_d    = pick_idx;
            if (BLANK_CYCLES > 0) begin
                state_d = ST_BLANK;
                blank_d = BLANK_INIT;
            end else begin
                state_d = ST_OWNED;
                grant_d = NUM_REQUESTERS'(1) << pick_idx;
                hold_d  = HOLD_INIT;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            last_q    <= LAST_RESET;
            hold_q    <= '0;
            blank_q   <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            point_q   <= '0;
            disp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            blank_q   <= blank_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            point_q   <= point_d;
            disp_q    <= disp_d;
        end
    end

    assign grant         = grant_q;
    assign data          = data_q;
    assign pointEnable   = point_q;
    assign displayEnable = disp_q;

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Directed checks of the display ownership arbiter: hold, round-robin, early release,
// aborted blank, asynchronous reset and the zero-blank variant.
module tb_display_owner_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int DW = D * 4;

    logic              clock = 1'b0;
    logic              resetN;
    logic [N-1:0]      request, request2;
    logic [N*DW-1:0]   requestData;
    logic [N*D-1:0]    requestPoint;
    logic [N-1:0]      grant, grant2;
    logic [DW-1:0]     data, data2;
    logic [D-1:0]      pointEnable, pointEnable2;
    logic              displayEnable, displayEnable2;

    logic [DW-1:0]     img [N];
    logic [D-1:0]      pnt [N];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign requestData[g*DW +: DW] = img[g];
        assign requestPoint[g*D +: D]  = pnt[g];
    end

    display_owner_arbiter #(
        .NUM_REQUESTERS (N),
        .NUM_DIGITS     (D),
        .HOLD_CYCLES    (8),
        .BLANK_CYCLES   (2)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .request       (request),
        .requestData   (requestData),
        .requestPoint  (requestPoint),
        .grant         (grant),
        .data          (data),
        .pointEnable   (pointEnable),
        .displayEnable (displayEnable)
    );

    display_owner_arbiter #(
        .NUM_REQUESTERS (N),
        .NUM_DIGITS     (D),
        .HOLD_CYCLES    (8),
        .BLANK_CYCLES   (0)
    ) dut_nb (
        .clock         (clock),
        .resetN        (resetN),
        .request       (request2),
        .requestData   (requestData),
        .requestPoint  (requestPoint),
        .grant         (grant2),
        .data          (data2),
        .pointEnable   (pointEnable2),
        .displayEnable (displayEnable2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with both DUTs idle ("cycle 0").
    task automatic do_reset();
        resetN   = 1'b0;
        request  = '0;
        request2 = '0;
        repeat (2) @(posedge clock);
        #3;
        resetN = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        img[0] = 32'h0123_4567; pnt[0] = 8'hA5;
        img[1] = 32'h89AB_CDEF; pnt[1] = 8'h3C;
        img[2] = 32'h2468_ACE0; pnt[2] = 8'h0F;
        img[3] = 32'h1357_9BDF; pnt[3] = 8'hF0;
        resetN   = 1'b0;
        request  = '0;
        request2 = '0;
        #2;
        check("rst_grant", 64'(grant), 64'(4'b0000));
        check("rst_data",  64'(data), 64'(0));
        check("rst_point", 64'(pointEnable), 64'(0));
        check("rst_disp",  64'(displayEnable), 64'(0));

        // Single requester 2: two blank cycles, then held indefinitely.
        do_reset();
        request = 4'b0100;
        tick(); check("single_c1_grant", 64'(grant), 64'(4'b0000));
        tick(); check("single_c2_grant", 64'(grant), 64'(4'b0000));
        tick(); check("single_c3_grant", 64'(grant), 64'(4'b0100));
        check("single_c3_disp", 64'(displayEnable), 64'(0));
        tick(); check("single_c4_disp", 64'(displayEnable), 64'(1));
        check("single_c4_data", 64'(data), 64'(32'h2468_ACE0));
        check("single_c4_point", 64'(pointEnable), 64'(8'h0F));
        tick(20);
        check("single_hold_grant", 64'(grant), 64'(4'b0100));
        check("single_hold_disp", 64'(displayEnable), 64'(1));
        img[2] = 32'hDEAD_BEEF;
        tick(); check("single_data_latency", 64'(data), 64'(32'hDEAD_BEEF));
        request = 4'b0000;
        tick(); check("single_drop_grant", 64'(grant), 64'(4'b0000));
        tick(); check("single_drop_disp", 64'(displayEnable), 64'(0));
        check("single_drop_data", 64'(data), 64'(0));
        img[2] = 32'h2468_ACE0;

        // All four requesting: 10-cycle rotation, 8 owned + 2 blank.
        do_reset();
        request = 4'b1111;
        for (int t = 1; t <= 45; t++) begin
            int p;
            int own;
            logic [3:0] eg;
            logic ed;
            tick();
            p   = (t - 1) % 10;
            own = ((t - 1) / 10) % 4;
            eg  = (p >= 2) ? (4'b0001 << own) : 4'b0000;
            ed  = (p >= 3) || (p == 0 && t > 1);
            check($sformatf("rr_grant_t%0d", t), 64'(grant), 64'(eg));
            check($sformatf("rr_disp_t%0d", t), 64'(displayEnable), 64'(ed));
            if (p == 5) check($sformatf("rr_data_t%0d", t), 64'(data), 64'(img[own]));
        end

        // Owner 1 drops after 3 cycles with 3 waiting, then 3 drops with nobody waiting.
        do_reset();
        request = 4'b0010;
        tick(3); check("early_c3_grant", 64'(grant), 64'(4'b0010));
        request = 4'b1010;
        tick(); check("early_c4_grant", 64'(grant), 64'(4'b0010));
        tick(); check("early_c5_grant", 64'(grant), 64'(4'b0010));
        request = 4'b1000;
        tick(); check("early_c6_grant", 64'(grant), 64'(4'b0000));
        tick(); check("early_c7_grant", 64'(grant), 64'(4'b0000));
        tick(); check("early_c8_grant", 64'(grant), 64'(4'b1000));
        request = 4'b0000;
        tick(); check("early_idle_c9_grant", 64'(grant), 64'(4'b0000));
        tick(); check("early_idle_c10_disp", 64'(displayEnable), 64'(0));
        request = 4'b0001;
        tick(2); check("early_idle_c12_grant", 64'(grant), 64'(4'b0000));
        tick(); check("early_idle_c13_grant", 64'(grant), 64'(4'b0001));

        // Request 2 aborts its blank; 3 then beats 0 because lastOwner is 2.
        do_reset();
        request = 4'b0100;
        tick(); check("abort_c1_grant", 64'(grant), 64'(4'b0000));
        request = 4'b0000;
        tick(); check("abort_c2_grant", 64'(grant), 64'(4'b0000));
        check("abort_c2_disp", 64'(displayEnable), 64'(0));
        request = 4'b1001;
        tick(); check("abort_c3_grant", 64'(grant), 64'(4'b0000));
        tick(); check("abort_c4_grant", 64'(grant), 64'(4'b0000));
        tick(); check("abort_c5_grant", 64'(grant), 64'(4'b1000));

        // Asynchronous reset while requester 1 owns the display.
        do_reset();
        request = 4'b0010;
        tick(3); check("arst_pre_grant", 64'(grant), 64'(4'b0010));
        tick(2); check("arst_pre_disp", 64'(displayEnable), 64'(1));
        #2;
        resetN = 1'b0;
        #1;
        check("arst_grant", 64'(grant), 64'(4'b0000));
        check("arst_data",  64'(data), 64'(0));
        check("arst_point", 64'(pointEnable), 64'(0));
        check("arst_disp",  64'(displayEnable), 64'(0));
        #1;
        request = 4'b0011;
        resetN  = 1'b1;
        @(posedge clock);
        #1;
        check("arst_after_c1_grant", 64'(grant), 64'(4'b0000));
        tick(); check("arst_after_c2_grant", 64'(grant), 64'(4'b0000));
        tick(); check("arst_after_c3_grant", 64'(grant), 64'(4'b0001));

        // Zero-blank instance: grant the cycle after the request, direct hand-off.
        do_reset();
        check("nb_c0_grant", 64'(grant2), 64'(4'b0000));
        request2 = 4'b0001;
        tick(); check("nb_c1_grant", 64'(grant2), 64'(4'b0001));
        check("nb_c1_disp", 64'(displayEnable2), 64'(0));
        tick(); check("nb_c2_disp", 64'(displayEnable2), 64'(1));
        check("nb_c2_data", 64'(data2), 64'(32'h0123_4567));
        check("nb_c2_point", 64'(pointEnable2), 64'(8'hA5));
        request2 = 4'b0011;
        tick(6); check("nb_c8_grant", 64'(grant2), 64'(4'b0001));
        tick(); check("nb_c9_grant", 64'(grant2), 64'(4'b0010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_owner_arbiter.md
Name: display_owner_arbiter

Overview:
Shares one multiplexed seven-segment display between several requesters, e.g. a status readout, a debug counter and an alarm source. Grants ownership round-robin and guarantees each owner a minimum hold time. Inserts a blanking gap on every ownership change so one requester's digits never flash into another's. Sits directly in front of the seven-segment controller: its data and point outputs feed the controller, and its enable output gates the controller's digit enables.

Parameters:
NUM_REQUESTERS, 4, number of requesters, 2..8
NUM_DIGITS, 8, digits per display image; each requester supplies NUM_DIGITS*4 data bits
HOLD_CYCLES, 1000000, minimum clock cycles an owner keeps the display before it can be pre-empted (10 ms at 100 MHz), >=1
BLANK_CYCLES, 1000, clock cycles the display is blanked between owners; 0 means no gap

Ports:
clock  in  1  system clock
resetN  in  1  asynchronous active-low reset
request  in  NUM_REQUESTERS  level request per requester, held high while it wants the display
requestData  in  NUM_REQUESTERS*NUM_DIGITS*4  flattened images, requester i at [i*NUM_DIGITS*4 +: NUM_DIGITS*4]
requestPoint  in  NUM_REQUESTERS*NUM_DIGITS  flattened decimal-point masks, requester i at [i*NUM_DIGITS +: NUM_DIGITS]
grant  out  NUM_REQUESTERS  one-hot current owner, all-zero when there is no owner
data  out  NUM_DIGITS*4  image for the display controller
pointEnable  out  NUM_DIGITS  decimal-point mask for the display controller
displayEnable  out  1  high only while an owner's image is shown; low blanks all digits

Behaviour:
- Reset values: state IDLE, grant=0, data=0, pointEnable=0, displayEnable=0, lastOwner=NUM_REQUESTERS-1 (so requester 0 wins first), counters=0.
- Reset is asynchronous. Asserting it mid-operation drops grant and displayEnable immediately, with no blank gap.
- Winner pick (combinational): first asserted request searching upward from lastOwner+1, wrapping modulo NUM_REQUESTERS. An optional exclude input removes one index from the search.
- State IDLE:
  - Outputs: grant=0, displayEnable=0, data and pointEnable forced to 0.
  - Any request: latch the winner as pending and set lastOwner=winner.
  - If BLANK_CYCLES>0: go to BLANK with blankCount=BLANK_CYCLES-1. Otherwise go straight to OWNED.
- State BLANK:
  - Outputs: displayEnable=0, grant=0, data and pointEnable=0.
  - blankCount decrements each cycle.
  - When blankCount==0 and request[pending] is high: go to OWNED, grant=onehot(pending), holdCount=HOLD_CYCLES-1.
  - If request[pending] falls at any point during BLANK: go to IDLE, which re-arbitrates on the next cycle.
- State OWNED:
  - Each cycle, register data, pointEnable and displayEnable=1 from the owner's slice. This gives 1-cycle latency from requestData to data, and displayEnable rises on the first OWNED cycle's registered output.
  - holdCount decrements and saturates at 0.
- Releasing ownership in OWNED:
  - Owner drops its request: release immediately, regardless of holdCount. If another requester is asserted, go to BLANK with that winner pending (lastOwner=winner). Otherwise go to IDLE.
  - holdCount==0 and another requester asserted (winner search excludes the owner): pre-empt by going to BLANK with the winner pending.
  - holdCount==0 and the owner is the only requester: stay in OWNED indefinitely.
- Simultaneous events:
  - Owner drop and hold expiry in the same cycle: treat as the drop.
  - A request rising in the same cycle another's grant starts is arbitrated at the next release point.
- Exactly one grant bit is high in OWNED, and no grant bit is high in IDLE or BLANK.
- Counter widths are $clog2(HOLD_CYCLES+1) and $clog2(BLANK_CYCLES+1), minimum 1 bit.
- lastOwner updates only when a winner is latched, so round-robin fairness holds across aborted BLANK phases.

Decomposition:
- Shared constants header: state encodings (IDLE=2'd0, BLANK=2'd1, OWNED=2'd2) and a width helper for the counters.
- One sub-module, round_robin_picker: parameter N; inputs request, lastIndex, excludeEnable, excludeIndex; outputs valid and winner index.
- The main block holds the state machine, the two counters and the output registers.

Test Plan:
- Parameters NUM_REQUESTERS=4, HOLD_CYCLES=8, BLANK_CYCLES=2 unless noted.
- Single requester: request=4'b0100 after reset -> 2 blank cycles, then grant=4'b0100; data equals requestData slice 2 one cycle later; displayEnable=1; held indefinitely.
- Pre-emption and fairness: request=4'b1111 constant -> grants 0,1,2,3,0 in order, each for exactly 8 cycles of displayEnable=1, separated by 2 cycles of displayEnable=0 and grant=0.
- Early release: owner 1 drops its request after 3 cycles with request 3 pending -> grant=0 on the next cycle, 2 blank cycles, then grant=4'b1000; with no other request pending the block returns to IDLE instead.
- Aborted blank: request 2 rises then falls during BLANK -> return to IDLE, no grant issued; request 3 raised afterwards is granted, since lastOwner=2.
- Reset mid-OWNED: pull resetN low while grant=4'b0010 -> grant, data, pointEnable and displayEnable go to 0 asynchronously; after release requester 0 wins first.
- BLANK_CYCLES=0: request=4'b0001 -> grant asserted on the cycle after the request, with no blank gap.
